// File: rtl/usb_tx_scheduler.sv
// usb_tx_scheduler: arbitrates handshake and data packet requests and serialises
// the PID byte ({~pid, pid}) followed by up to MAX_LEN payload bytes, LSB first,
// toward the CRC/bit-stuffer chain. Each packet is followed by GAP_CYCLES idle cycles.
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   hs_req, hs_pid          handshake request (PID only), fixed priority
//   dp_req, dp_pid, dp_len  data packet request, PID and payload length
//   dp_byte, dp_byte_ack    payload byte, pulsed ack in the cycle it is captured
//   bs_ready                bit stuffer ready; 0 holds the current bit
//   hs_grant, dp_grant      grant pulses in the IDLE cycle the request is taken
//   tx_bit, tx_valid        registered serial bit and its valid flag
//   busy, done              not-idle flag, end-of-packet pulse (last GAP cycle)
module usb_tx_scheduler #(
  parameter int unsigned MAX_LEN    = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       hs_req,
  input  logic [3:0] hs_pid,
  input  logic       dp_req,
  input  logic [3:0] dp_pid,
  input  logic [3:0] dp_len,
  input  logic [7:0] dp_byte,
  input  logic       bs_ready,
  output logic       hs_grant,
  output logic       dp_grant,
  output logic       dp_byte_ack,
  output logic       tx_bit,
  output logic       tx_valid,
  output logic       busy,
  output logic       done
);

  localparam int unsigned LEN_W = 4;
  localparam int unsigned GAP_W = 4;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND_PID, SEND_DATA, GAP} state_e;

  state_e           state_q, state_d;
  logic [7:0]       sh_q, sh_d;
  logic [2:0]       bit_q, bit_d;
  logic [LEN_W-1:0] byte_q, byte_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             tx_bit_q, tx_bit_d;
  logic             tx_valid_q, tx_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic hs_grant_c, dp_grant_c, ack_c;
  logic load_byte, enter_gap, shift_bit;

  // State register and all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      len_q      <= '0;
      gap_q      <= '0;
      tx_bit_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      len_q      <= len_d;
      gap_q      <= gap_d;
      tx_bit_q   <= tx_bit_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and datapath; everything holds unless a bit is accepted.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    len_d      = len_q;
    gap_d      = gap_q;
    tx_bit_d   = tx_bit_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;
    hs_grant_c = 1'b0;
    dp_grant_c = 1'b0;
    ack_c      = 1'b0;
    load_byte  = 1'b0;
    enter_gap  = 1'b0;
    shift_bit  = 1'b0;

    case (state_q)
      IDLE: begin
        if (hs_req) begin
          hs_grant_c = 1'b1;
          sh_d       = {~hs_pid, hs_pid};
          len_d      = '0;
        end else if (dp_req) begin
          dp_grant_c = 1'b1;
          sh_d       = {~dp_pid, dp_pid};
          len_d      = (dp_len > MAX_LEN_L) ? MAX_LEN_L : dp_len;
        end
        // First PID bit goes out in the cycle right after the grant.
        if (hs_req || dp_req) begin
          state_d    = SEND_PID;
          bit_d      = '0;
          byte_d     = '0;
          tx_valid_d = 1'b1;
          tx_bit_d   = sh_d[0];
        end
      end
      SEND_PID: begin
        if (bs_ready) begin
          if (bit_q == 3'd7) begin
            if (len_q != '0) begin
              state_d   = SEND_DATA;
              load_byte = 1'b1;
            end else begin
              enter_gap = 1'b1;
            end
          end else begin
            shift_bit = 1'b1;
          end
        end
      end
      SEND_DATA: begin
        if (bs_ready) begin
          if (bit_q == 3'd7) begin
            byte_d = byte_q + LEN_W'(1);
            if (byte_d == len_q) enter_gap = 1'b1;
            else                 load_byte = 1'b1;
          end else begin
            shift_bit = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d  = gap_q + GAP_W'(1);
          done_d = (gap_d == GAP_LAST);
        end
      end
      default: state_d = IDLE;
    endcase

    if (shift_bit) begin
      sh_d     = {1'b0, sh_q[7:1]};
      tx_bit_d = sh_q[1];
      bit_d    = bit_q + 3'd1;
    end
    // Byte is sampled on the same edge the ack is seen, so the requester may change it afterwards.
    if (load_byte) begin
      ack_c    = 1'b1;
      sh_d     = dp_byte;
      bit_d    = '0;
      tx_bit_d = dp_byte[0];
    end
    if (enter_gap) begin
      state_d    = GAP;
      gap_d      = '0;
      sh_d       = '0;
      tx_valid_d = 1'b0;
      tx_bit_d   = 1'b0;
      done_d     = (GAP_LAST == '0);
    end

    busy_d = (state_d != IDLE);
  end

  // Grants and ack are decoded in the cycle the request/byte is taken; reset masks them.
  assign hs_grant    = hs_grant_c & ~reset;
  assign dp_grant    = dp_grant_c & ~reset;
  assign dp_byte_ack = ack_c & ~reset;
  assign tx_bit      = tx_bit_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Directed testbench for usb_tx_scheduler: handshake packet, priority and
// back-to-back spacing, stall, zero length, length clamp and mid-packet reset.
module tb_usb_tx_scheduler;

  logic       clock, reset;
  logic       hs_req, dp_req, bs_ready;
  logic [3:0] hs_pid, dp_pid, dp_len;
  logic [7:0] dp_byte;
  logic       hs_grant, dp_grant, dp_byte_ack, tx_bit, tx_valid, busy, done;

  usb_tx_scheduler #(.MAX_LEN(8), .GAP_CYCLES(2)) dut (
    .clock(clock), .reset(reset),
    .hs_req(hs_req), .hs_pid(hs_pid),
    .dp_req(dp_req), .dp_pid(dp_pid), .dp_len(dp_len), .dp_byte(dp_byte),
    .bs_ready(bs_ready),
    .hs_grant(hs_grant), .dp_grant(dp_grant), .dp_byte_ack(dp_byte_ack),
    .tx_bit(tx_bit), .tx_valid(tx_valid), .busy(busy), .done(done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_cmp = 0;
  int n_fail = 0;

  // Capture of one packet, cycle 0 = the IDLE cycle where the request is presented.
  logic [127:0] cap;
  int n_valid, n_ack, n_done, n_busy, n_hsg, n_dpg, n_gapbit;
  int hsg_cyc, dpg_cyc, done_cyc;
  logic timed_out;
  logic [7:0] data_q[$];

  task automatic run_pkt(input logic hs, input logic dp, input logic [3:0] hpid,
                         input logic [3:0] dpid, input logic [3:0] len,
                         input int stall_at, input int budget);
    logic drop_hs, drop_dp, ack_seen, stalled, seen_done;
    cap = '0; n_valid = 0; n_ack = 0; n_done = 0; n_busy = 0; n_hsg = 0; n_dpg = 0;
    n_gapbit = 0; hsg_cyc = -1; dpg_cyc = -1; done_cyc = -1; timed_out = 1'b0;
    drop_hs = 1'b0; drop_dp = 1'b0; ack_seen = 1'b0; stalled = 1'b0; seen_done = 1'b0;
    @(negedge clock);
    hs_req = hs; dp_req = dp; hs_pid = hpid; dp_pid = dpid; dp_len = len;
    dp_byte = (data_q.size() > 0) ? data_q[0] : 8'h00;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (cyc > 0) begin
        @(negedge clock);
        if (drop_hs) begin hs_req = 1'b0; drop_hs = 1'b0; end
        if (drop_dp) begin dp_req = 1'b0; drop_dp = 1'b0; end
        if (ack_seen) begin
          dp_byte = (n_ack < data_q.size()) ? data_q[n_ack] : 8'h00;
          ack_seen = 1'b0;
        end
      end
      if (stall_at >= 0 && !stalled && tx_valid && n_valid == stall_at) begin
        bs_ready = 1'b0;
        stalled  = 1'b1;
      end else begin
        bs_ready = 1'b1;
      end
      #1;
      if (hs_grant) begin n_hsg++; hsg_cyc = cyc; drop_hs = 1'b1; end
      if (dp_grant) begin n_dpg++; dpg_cyc = cyc; drop_dp = 1'b1; end
      if (tx_valid) begin cap = {cap[126:0], tx_bit}; n_valid++; end
      else if (tx_bit) n_gapbit++;
      if (dp_byte_ack) begin n_ack++; ack_seen = 1'b1; end
      if (busy) n_busy++;
      if (done) begin n_done++; done_cyc = cyc; seen_done = 1'b1; break; end
    end
    if (!seen_done) timed_out = 1'b1;
    bs_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; hs_req = 1'b1; dp_req = 1'b1; hs_pid = 4'hA; dp_pid = 4'h3;
    dp_len = 4'd2; dp_byte = 8'hFF; bs_ready = 1'b1;
    #23;
    n_cmp++;
    if ({hs_grant, dp_grant, dp_byte_ack, tx_bit, tx_valid, busy, done} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b want 0000000",
               {hs_grant, dp_grant, dp_byte_ack, tx_bit, tx_valid, busy, done});
    end
    hs_req = 1'b0; dp_req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_hs_packet();
    data_q = {};
    run_pkt(1'b1, 1'b0, 4'b0010, 4'h0, 4'd0, -1, 60);
    n_cmp++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL hs_timeout got %b want 0", timed_out); end
    n_cmp++; if (hsg_cyc !== 0 || n_hsg !== 1 || n_dpg !== 0) begin n_fail++; $display("FAIL hs_grant got cyc %0d n %0d dp %0d want 0 1 0", hsg_cyc, n_hsg, n_dpg); end
    n_cmp++; if (n_valid !== 8) begin n_fail++; $display("FAIL hs_valid_count got %0d want 8", n_valid); end
    n_cmp++; if (cap[7:0] !== 8'b01001011) begin n_fail++; $display("FAIL hs_bits got %b want 01001011", cap[7:0]); end
    n_cmp++; if (done_cyc !== 10 || n_done !== 1) begin n_fail++; $display("FAIL hs_done got cyc %0d n %0d want 10 1", done_cyc, n_done); end
    n_cmp++; if (n_busy !== 10) begin n_fail++; $display("FAIL hs_busy got %0d want 10", n_busy); end
    n_cmp++; if (n_gapbit !== 0 || n_ack !== 0) begin n_fail++; $display("FAIL hs_gap_quiet got gapbits %0d acks %0d want 0 0", n_gapbit, n_ack); end
  endtask

  task automatic test_back_to_back();
    data_q = {8'h55};
    run_pkt(1'b1, 1'b1, 4'b0010, 4'b0011, 4'd1, -1, 60);
    n_cmp++; if (n_hsg !== 1 || n_dpg !== 0 || done_cyc !== 10) begin n_fail++; $display("FAIL prio_first got hs %0d dp %0d done %0d want 1 0 10", n_hsg, n_dpg, done_cyc); end
    run_pkt(1'b0, 1'b1, 4'b0010, 4'b0011, 4'd1, -1, 60);
    n_cmp++; if (dpg_cyc !== 0 || n_dpg !== 1 || n_hsg !== 0) begin n_fail++; $display("FAIL prio_second got dp cyc %0d n %0d hs %0d want 0 1 0", dpg_cyc, n_dpg, n_hsg); end
    n_cmp++; if (n_valid !== 16 || cap[15:0] !== 16'b11000011_10101010) begin n_fail++; $display("FAIL prio_data got %0d %b want 16 1100001110101010", n_valid, cap[15:0]); end
    n_cmp++; if (n_ack !== 1 || done_cyc !== 18) begin n_fail++; $display("FAIL prio_ack_done got %0d %0d want 1 18", n_ack, done_cyc); end
  endtask

  task automatic test_stall();
    data_q = {8'hA5, 8'h3C};
    run_pkt(1'b0, 1'b1, 4'h0, 4'b0011, 4'd2, 13, 100);
    n_cmp++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL stall_timeout got %b want 0", timed_out); end
    n_cmp++; if (n_valid !== 25) begin n_fail++; $display("FAIL stall_valid_count got %0d want 25", n_valid); end
    n_cmp++; if (cap[24:0] !== 25'b11000011_101001101_00111100) begin n_fail++; $display("FAIL stall_bits got %b want 1100001110100110100111100", cap[24:0]); end
    n_cmp++; if (n_ack !== 2 || done_cyc !== 27) begin n_fail++; $display("FAIL stall_ack_done got %0d %0d want 2 27", n_ack, done_cyc); end
  endtask

  task automatic test_zero_len();
    data_q = {};
    run_pkt(1'b0, 1'b1, 4'h0, 4'b0011, 4'd0, -1, 60);
    n_cmp++; if (n_valid !== 8 || cap[7:0] !== 8'b11000011) begin n_fail++; $display("FAIL zero_bits got %0d %b want 8 11000011", n_valid, cap[7:0]); end
    n_cmp++; if (n_ack !== 0 || done_cyc !== 10 || n_done !== 1) begin n_fail++; $display("FAIL zero_ack_done got %0d %0d %0d want 0 10 1", n_ack, done_cyc, n_done); end
  endtask

  task automatic test_clamp();
    data_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_pkt(1'b0, 1'b1, 4'h0, 4'b0011, 4'd12, -1, 200);
    n_cmp++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL clamp_timeout got %b want 0", timed_out); end
    n_cmp++; if (n_ack !== 8 || n_valid !== 72) begin n_fail++; $display("FAIL clamp_counts got acks %0d valid %0d want 8 72", n_ack, n_valid); end
    n_cmp++; if (cap[15:0] !== 16'b11100000_00010000) begin n_fail++; $display("FAIL clamp_tail got %b want 1110000000010000", cap[15:0]); end
    n_cmp++; if (done_cyc !== 74) begin n_fail++; $display("FAIL clamp_done got %0d want 74", done_cyc); end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    dp_req = 1'b1; dp_pid = 4'b1011; dp_len = 4'd2; dp_byte = 8'hFF; bs_ready = 1'b1;
    @(negedge clock);
    dp_req = 1'b0;
    repeat (10) @(negedge clock);
    n_cmp++; if (tx_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_active got %b%b want 11", tx_valid, busy); end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({hs_grant, dp_grant, dp_byte_ack, tx_bit, tx_valid, busy, done} !== 7'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got %b want 0000000",
               {hs_grant, dp_grant, dp_byte_ack, tx_bit, tx_valid, busy, done});
    end
    @(negedge clock);
    reset = 1'b0;
    data_q = {8'h81};
    run_pkt(1'b0, 1'b1, 4'h0, 4'b1011, 4'd1, -1, 60);
    n_cmp++; if (n_valid !== 16 || cap[15:0] !== 16'b11010010_10000001) begin n_fail++; $display("FAIL mid_restart_bits got %0d %b want 16 1101001010000001", n_valid, cap[15:0]); end
    n_cmp++; if (done_cyc !== 18 || n_ack !== 1) begin n_fail++; $display("FAIL mid_restart_done got %0d %0d want 18 1", done_cyc, n_ack); end
  endtask

  initial begin
    test_reset();
    test_hs_packet();
    test_back_to_back();
    test_stall();
    test_zero_len();
    test_clamp();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
